cdb_result_buffer: RTL and testbench
====================================

// Module: cdb_result_buffer
// PURPOSE
//  Transmit side of the functional-unit -> cdb_scheduler valid/yumi handshake.
//  Sits at the output of each FU (add, multiply, divide, memory load path).
//  Holds up to DEPTH completed results in a FIFO while the CDB is granted to others.
//  Presents the oldest result to cdb_scheduler and drops it on yumi_in.
//  Lets the FU keep issuing while the CDB is contended; flushed on mispredict.
// PARAMETERS
//  DEPTH     2   result slots, >=1, any integer (power of 2 not required)
//  CNT_W     $clog2(DEPTH+1)   width of occupancy count
// PORTS
//  clk        in   1              clock, all state on posedge
//  reset      in   1              asynchronous, active-high; clears all state
//  flush      in   1              synchronous squash (driven by mispredicted)
//  in_valid   in   1              FU has a completed result this cycle
//  in_packet  in   CDB_packet_t   FU result (ROB entry, value, branch outcome)
//  in_ready   out  1              buffer accepts in_packet this cycle
//  valid_out  out  1              result presented to cdb_scheduler
//  out        out  CDB_packet_t   oldest buffered result
//  yumi_in    in   1              cdb_scheduler consumes out this cycle
//  count      out  CNT_W          occupancy, for fu_scheduler ready gating
// BEHAVIOUR
//  - Reset (async): head=tail=0, count=0, valid_out=0, out='0, in_ready=1.
//  - Enqueue: in_valid & in_ready at edge N -> slot[tail]=in_packet, tail++.
//  - in_ready = (count < DEPTH); a full buffer does not accept even with yumi_in
//    high the same cycle (no combinational yumi->ready path).
//  - Dequeue: yumi_in & valid_out at edge -> head++, count--.
//  - yumi_in while valid_out=0 ignored, state unchanged (bench asserts never occurs).
//  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (compare, not bit truncation).
//  - valid_out = (count != 0); out = slot[head]; out = '0 when empty.
//  - Latency (no bypass): accepted at edge N -> valid_out high after edge N.
//  - Ordering strictly FIFO; no reordering by ROB entry or age.
//  - flush: at next edge head=tail=count=0; flush beats enqueue/dequeue in
//    same cycle (in_packet dropped, yumi_in has no further effect).
//  - Reset mid-operation: buffered results discarded, no partial packet on out.
// CONFIGURATION
//  CDB_BYPASS_EN defined:
//   - when count==0 & in_valid & ~flush: out=in_packet, valid_out=1 same cycle.
//   - if yumi_in also high: packet not stored, count stays 0.
//   - if yumi_in low: packet stored as normal, presented again next cycle.
//   - flush high forces valid_out=0 on the bypass path.
//  CDB_BYPASS_EN undefined: registered output only, one-cycle min latency.
// TESTING
//  1 reset mid-stream: 2 entries held, assert reset -> count=0, valid_out=0
//    immediately (async), in_ready=1.
//  2 fill/drain DEPTH=2: enq ROB 3 val 0x11, ROB 5 val 0x22, yumi low ->
//    in_ready=0, count=2; yumi 2 cycles -> out ROB 3 then ROB 5, count=0.
//  3 wrap: DEPTH=3, push/pop 7 packets with ROB 0..6, yumi every other cycle
//    -> out order 0..6, no loss, no duplicate.
//  4 simultaneous enq+deq at count=1: count stays 1, next out = new packet.
//  5 flush with in_valid & yumi_in high, count=2 -> count=0 next cycle,
//    valid_out=0, flushed packet never appears.
//  6 CDB_BYPASS_EN: empty, in_valid ROB 9 val 0x7, yumi_in same cycle ->
//    valid_out=1, out ROB 9 that cycle, count stays 0; undefined -> valid_out
//    rises next cycle.

Source files
------------

// File: rtl/cdb_result_buffer.sv
// cdb_result_buffer: FIFO of completed FU results feeding cdb_scheduler over valid/yumi; CDB_BYPASS_EN adds an empty-buffer bypass.
// Latency: accepted at edge N -> presented after edge N (same cycle with CDB_BYPASS_EN when empty); flush squashes at the next edge.
// Backpressure: in_ready drops once DEPTH results are held; a same-cycle yumi_in never reopens a slot.

package cdb_pkg;
    typedef struct packed {
        logic [4:0]  rob_entry;
        logic [31:0] value;
        logic        branch_taken;
    } CDB_packet_t;
endpackage

module cdb_result_buffer
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  CDB_packet_t      in_packet,
    output logic             in_ready,
    output logic             valid_out,
    output CDB_packet_t      out,
    input  logic             yumi_in,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    CDB_packet_t      slot [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             not_empty;
    logic             bypass_hit;
    logic             enq;
    logic             deq;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty = (count != '0);
    assign in_ready  = (count < FULL);
    assign deq       = yumi_in & not_empty & ~flush;

`ifdef CDB_BYPASS_EN
    // A bypassed packet consumed in the same cycle never occupies a slot.
    assign bypass_hit = ~not_empty & in_valid & ~flush;
    assign enq        = in_valid & in_ready & ~flush & ~(bypass_hit & yumi_in);
`else
    assign bypass_hit = 1'b0;
    assign enq        = in_valid & in_ready & ~flush;
`endif

    always_comb begin
        valid_out = not_empty | bypass_hit;
        out       = '0;
        if (not_empty) begin
            out = slot[head];
        end else if (bypass_hit) begin
            out = in_packet;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                slot[tail] <= in_packet;
                tail       <= next_ptr(tail);
            end
            if (deq) begin
                head <= next_ptr(head);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cdb_result_buffer.sv
// Scoreboarded bench for cdb_result_buffer: a DEPTH=2 and a DEPTH=3 instance driven by directed vectors.
module tb_cdb_result_buffer;
    import cdb_pkg::*;

    typedef enum int {K_CNT2, K_RDY2, K_VLD2, K_OUT2Z, K_CNT3, K_Q2E, K_Q3E} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [63:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush2, in_valid2, in_ready2, valid_out2, yumi2;
    logic        flush3, in_valid3, in_ready3, valid_out3, yumi3;
    CDB_packet_t in_packet2, out2, in_packet3, out3;
    logic [1:0]  count2, count3;

    CDB_packet_t exp2[$];
    CDB_packet_t exp3[$];
    chk_t        chkq[$];
    int          checks = 0;
    int          failures = 0;

    cdb_result_buffer #(.DEPTH(2)) u2 (
        .clk(clk), .reset(reset), .flush(flush2), .in_valid(in_valid2),
        .in_packet(in_packet2), .in_ready(in_ready2), .valid_out(valid_out2),
        .out(out2), .yumi_in(yumi2), .count(count2)
    );

    cdb_result_buffer #(.DEPTH(3)) u3 (
        .clk(clk), .reset(reset), .flush(flush3), .in_valid(in_valid3),
        .in_packet(in_packet3), .in_ready(in_ready3), .valid_out(valid_out3),
        .out(out3), .yumi_in(yumi3), .count(count3)
    );

    always #5 clk = ~clk;

    function automatic CDB_packet_t mk(input logic [4:0] rob, input logic [31:0] val);
        CDB_packet_t p;
        p.rob_entry    = rob;
        p.value        = val;
        p.branch_taken = rob[0];
        return p;
    endfunction

    task automatic expect_state(input kind_t k, input string n, input logic [63:0] e);
        chk_t c;
        c.kind = k;
        c.name = n;
        c.exp  = e;
        chkq.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: consumes handshakes against the scoreboards and evaluates queued state checks.
    always @(negedge clk) begin
        CDB_packet_t e;
        chk_t        c;
        logic [63:0] act;
        if (valid_out2 && yumi2 && !flush2 && !reset) begin
            if (exp2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u2_unexpected_out: got %h expected none", out2);
            end else begin
                e = exp2.pop_front();
                cmp("u2_out", 64'(out2), 64'(e));
            end
        end
        if (valid_out3 && yumi3 && !flush3 && !reset) begin
            if (exp3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u3_unexpected_out: got %h expected none", out3);
            end else begin
                e = exp3.pop_front();
                cmp("u3_out", 64'(out3), 64'(e));
            end
        end
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            case (c.kind)
                K_CNT2:  act = 64'(count2);
                K_RDY2:  act = 64'(in_ready2);
                K_VLD2:  act = 64'(valid_out2);
                K_OUT2Z: act = 64'(out2);
                K_CNT3:  act = 64'(count3);
                K_Q2E:   act = 64'(exp2.size());
                default: act = 64'(exp3.size());
            endcase
            cmp(c.name, act, c.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int sent;
        reset = 1'b1;
        flush2 = 1'b0; in_valid2 = 1'b0; yumi2 = 1'b0; in_packet2 = '0;
        flush3 = 1'b0; in_valid3 = 1'b0; yumi3 = 1'b0; in_packet3 = '0;
        repeat (3) step();
        reset = 1'b0;
        expect_state(K_CNT2, "reset_count2", 0);
        expect_state(K_RDY2, "reset_ready2", 1);
        expect_state(K_VLD2, "reset_valid2", 0);
        expect_state(K_OUT2Z, "reset_out2", 0);
        expect_state(K_CNT3, "reset_count3", 0);

        // Fill to DEPTH=2, then a full buffer refuses a packet even with yumi high.
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd3, 32'h11); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd5, 32'h22); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd6, 32'h66); yumi2 = 1'b1;
        expect_state(K_CNT2, "full_count", 2);
        expect_state(K_RDY2, "full_ready", 0);
        expect_state(K_VLD2, "full_valid", 1);
        step(); in_valid2 = 1'b0;
        expect_state(K_CNT2, "drain1_count", 1);
        step(); yumi2 = 1'b0;
        expect_state(K_CNT2, "drained_count", 0);
        expect_state(K_VLD2, "drained_valid", 0);
        expect_state(K_OUT2Z, "drained_out", 0);
        expect_state(K_RDY2, "drained_ready", 1);

        // Simultaneous enqueue and dequeue at count=1.
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd1, 32'hA1); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd2, 32'hA2); exp2.push_back(in_packet2); yumi2 = 1'b1;
        expect_state(K_CNT2, "simul_pre_count", 1);
        step(); in_valid2 = 1'b0;
        expect_state(K_CNT2, "simul_post_count", 1);
        step(); yumi2 = 1'b0;
        expect_state(K_CNT2, "simul_drained_count", 0);

        // Flush with in_valid and yumi_in high while full.
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd7, 32'h77); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd8, 32'h88); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd9, 32'h99); yumi2 = 1'b1; flush2 = 1'b1;
        exp2.delete();
        expect_state(K_CNT2, "preflush_count", 2);
        step(); in_valid2 = 1'b0; yumi2 = 1'b0; flush2 = 1'b0;
        expect_state(K_CNT2, "flush_count", 0);
        expect_state(K_VLD2, "flush_valid", 0);
        expect_state(K_RDY2, "flush_ready", 1);
        expect_state(K_OUT2Z, "flush_out", 0);
        step();
        expect_state(K_VLD2, "flush_valid_later", 0);
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd12, 32'hC); exp2.push_back(in_packet2);
        step(); in_valid2 = 1'b0; yumi2 = 1'b1;
        expect_state(K_CNT2, "postflush_count", 1);
        step(); yumi2 = 1'b0;
        expect_state(K_CNT2, "postflush_drained", 0);

        // Wrap on DEPTH=3: 7 packets, yumi on alternate cycles.
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (sent == 7 && count3 == 2'd0) break;
            in_valid3  = (sent < 7);
            in_packet3 = mk(sent[4:0], 32'h300 + 32'(sent));
            if (in_valid3 && in_ready3) begin
                exp3.push_back(in_packet3);
                sent++;
            end
            yumi3 = (c % 2 == 1) && (count3 != 2'd0);
        end
        in_valid3 = 1'b0;
        yumi3 = 1'b0;
        expect_state(K_CNT3, "wrap_count", 0);
        expect_state(K_Q3E, "wrap_all_seen", 0);

        // Reset mid-stream with two results held.
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd10, 32'hAA); exp2.push_back(in_packet2);
        step(); in_packet2 = mk(5'd11, 32'hBB); exp2.push_back(in_packet2);
        step(); in_valid2 = 1'b0;
        expect_state(K_CNT2, "prereset_count", 2);
        step();
        reset = 1'b1;
        exp2.delete();
        expect_state(K_CNT2, "midreset_count", 0);
        expect_state(K_VLD2, "midreset_valid", 0);
        expect_state(K_RDY2, "midreset_ready", 1);
        expect_state(K_OUT2Z, "midreset_out", 0);
        step(); step(); reset = 1'b0;
        step();
        expect_state(K_VLD2, "postreset_valid", 0);

        // Bypass behaviour on an empty buffer.
        step(); in_valid2 = 1'b1; in_packet2 = mk(5'd9, 32'h7); exp2.push_back(in_packet2);
`ifdef CDB_BYPASS_EN
        yumi2 = 1'b1;
        expect_state(K_VLD2, "bypass_valid_same", 1);
        step(); in_valid2 = 1'b0; yumi2 = 1'b0;
        expect_state(K_CNT2, "bypass_count", 0);
        expect_state(K_VLD2, "bypass_valid_after", 0);
`else
        expect_state(K_VLD2, "nobypass_valid_same", 0);
        step(); in_valid2 = 1'b0; yumi2 = 1'b1;
        expect_state(K_VLD2, "nobypass_valid_next", 1);
        expect_state(K_CNT2, "nobypass_count", 1);
        step(); yumi2 = 1'b0;
        expect_state(K_CNT2, "nobypass_drained", 0);
`endif

        step();
        expect_state(K_Q2E, "u2_all_seen", 0);
        expect_state(K_Q3E, "u3_all_seen", 0);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
